mem_stage: RTL and testbench

Memory-access pipeline stage between the execute stage and the writeback stage. It accepts one instruction per handshake on `es_to_ms_bus`. For loads and stores whose SRAM request was already accepted upstream, it waits for `data_sram_data_ok`, then aligns and extends load data. It forwards results and stall hints to decode, and drops stale memory responses that belong to instructions flushed by writeback.

---
 rtl/mem_stage.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Waits for the SRAM response of loads/stores, aligns and extends load data,
// buffers a response that arrives while writeback stalls, forwards results
// to decode and silently drops responses owned by flushed instructions.
module mem_stage #(
  localparam int unsigned ES_TO_MS_BUS_WD = 164,
  localparam int unsigned MS_TO_WS_BUS_WD = 157,
  localparam int unsigned MS_TO_DS_BUS_WD = 55
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  output logic                       ms_ex_int,
  input  logic                       ws_block
);

  localparam int unsigned DATA_W = 32;

  // Upstream payload, MSB first.
  typedef struct packed {
    logic              rdcntid;
    logic              has_int;
    logic              ine_exce;
    logic              mem_exce;
    logic              brk_exce;
    logic              pc_exce;
    logic              ertn;
    logic              sys_exce;
    logic [13:0]       csr_num;
    logic              csr_we;
    logic [DATA_W-1:0] csr_wdata;
    logic [DATA_W-1:0] csr_wmask;
    logic [4:0]        ld_inst;
    logic              res_from_mem;
    logic              mem_we;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] pc;
  } es_bus_t;

  // Downstream payload, MSB first.
  typedef struct packed {
    logic              rdcntid;
    logic              has_int;
    logic              ine_exce;
    logic              mem_exce;
    logic              brk_exce;
    logic              pc_exce;
    logic              ertn;
    logic              sys_exce;
    logic [13:0]       csr_num;
    logic              csr_we;
    logic [DATA_W-1:0] csr_wdata;
    logic [DATA_W-1:0] csr_wmask;
    logic              gr_we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] final_result;
    logic [DATA_W-1:0] pc;
  } ws_bus_t;

  // Forwarding / interlock payload to decode, MSB first.
  typedef struct packed {
    logic              rdcntid_v;
    logic              csr_gr;
    logic [13:0]       csr_num;
    logic              we;
    logic [4:0]        dest;
    logic [DATA_W-1:0] final_result;
    logic              ld_pending;
  } ds_bus_t;

  // State
  logic              ms_valid_q, ms_valid_d;
  es_bus_t           es_q, es_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic              rbuf_valid_q, rbuf_valid_d;
  logic              discard_q, discard_d;

  // Combinational helpers
  logic              mem_op;
  logic              data_ok_eff;
  logic              ms_ready_go;
  logic              ms_leave;
  logic [DATA_W-1:0] mem_rdata;
  logic [7:0]        lane_byte;
  logic [15:0]       lane_half;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] final_result;
  ws_bus_t           ws_bus;
  ds_bus_t           ds_bus;

  // Handshake: an outstanding SRAM transaction exists only for a non-faulting memory op.
  always_comb begin
    mem_op         = (es_q.res_from_mem || es_q.mem_we) && !es_q.mem_exce;
    data_ok_eff    = data_sram_data_ok && !discard_q;
    ms_ready_go    = !mem_op || data_ok_eff || rbuf_valid_q;
    ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    ms_to_ws_valid = ms_valid_q && ms_ready_go;
    ms_leave       = ms_to_ws_valid && ws_allowin;
  end

  // Load data alignment: buffered word wins over the live response.
  always_comb begin
    mem_rdata = rbuf_valid_q ? rbuf_q : data_sram_rdata;
    case (es_q.result[1:0])
      2'd0:    lane_byte = mem_rdata[7:0];
      2'd1:    lane_byte = mem_rdata[15:8];
      2'd2:    lane_byte = mem_rdata[23:16];
      default: lane_byte = mem_rdata[31:24];
    endcase
    lane_half = es_q.result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (es_q.ld_inst[0]) begin
      load_data = mem_rdata;
    end else if (es_q.ld_inst[1]) begin
      load_data = {{24{lane_byte[7]}}, lane_byte};
    end else if (es_q.ld_inst[3]) begin
      load_data = {24'd0, lane_byte};
    end else if (es_q.ld_inst[2]) begin
      load_data = {{16{lane_half[15]}}, lane_half};
    end else if (es_q.ld_inst[4]) begin
      load_data = {16'd0, lane_half};
    end else begin
      load_data = mem_rdata;
    end
    final_result = es_q.res_from_mem ? load_data : es_q.result;
  end

  // Occupancy and payload capture; a flush overrides any upstream transfer.
  always_comb begin
    ms_valid_d = ms_valid_q;
    es_d       = es_q;
    if (ws_block) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (es_to_ms_valid && ms_allowin) begin
      es_d = es_bus_t'(es_to_ms_bus);
    end
  end

  // Response buffer holds data that arrived while writeback was stalled.
  always_comb begin
    rbuf_valid_d = rbuf_valid_q;
    rbuf_d       = rbuf_q;
    if (ws_block || ms_leave) begin
      rbuf_valid_d = 1'b0;
    end else if (ms_valid_q && mem_op && data_ok_eff && !ws_allowin) begin
      rbuf_valid_d = 1'b1;
      rbuf_d       = data_sram_rdata;
    end
  end

  // Discard tracking: a flushed instruction still waiting on SRAM owns the next response.
  always_comb begin
    discard_d = discard_q;
    if (discard_q && data_sram_data_ok) begin
      discard_d = 1'b0;
    end
    if (ws_block && ms_valid_q && mem_op && !rbuf_valid_q && !data_ok_eff) begin
      discard_d = 1'b1;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      rbuf_valid_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      rbuf_valid_q <= rbuf_valid_d;
      discard_q    <= discard_d;
    end
  end

  // Payload registers need no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    es_q   <= es_d;
    rbuf_q <= rbuf_d;
  end

  // Downstream and forwarding payload assembly.
  always_comb begin
    ws_bus.rdcntid      = es_q.rdcntid;
    ws_bus.has_int      = es_q.has_int;
    ws_bus.ine_exce     = es_q.ine_exce;
    ws_bus.mem_exce     = es_q.mem_exce;
    ws_bus.brk_exce     = es_q.brk_exce;
    ws_bus.pc_exce      = es_q.pc_exce;
    ws_bus.ertn         = es_q.ertn;
    ws_bus.sys_exce     = es_q.sys_exce;
    ws_bus.csr_num      = es_q.csr_num;
    ws_bus.csr_we       = es_q.csr_we;
    ws_bus.csr_wdata    = es_q.csr_wdata;
    ws_bus.csr_wmask    = es_q.csr_wmask;
    ws_bus.gr_we        = es_q.gr_we;
    ws_bus.dest         = es_q.dest;
    ws_bus.final_result = final_result;
    ws_bus.pc           = es_q.pc;

    ds_bus.rdcntid_v    = ms_valid_q && es_q.rdcntid;
    ds_bus.csr_gr       = ms_valid_q && es_q.csr_we;
    ds_bus.csr_num      = es_q.csr_num;
    ds_bus.we           = ms_valid_q && es_q.gr_we;
    ds_bus.dest         = es_q.dest;
    ds_bus.final_result = final_result;
    ds_bus.ld_pending   = ms_valid_q && es_q.res_from_mem && !ms_ready_go;

    ms_ex_int = ms_valid_q && (es_q.sys_exce | es_q.ertn | es_q.mem_exce | es_q.brk_exce |
                               es_q.pc_exce | es_q.ine_exce | es_q.has_int);
  end

  assign ms_to_ws_bus = ws_bus;
  assign ms_to_ds_bus = ds_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage.
module tb_mem_stage;

  logic         clk;
  logic         reset;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [163:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [156:0] ms_to_ws_bus;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic [54:0]  ms_to_ds_bus;
  logic         ms_ex_int;
  logic         ws_block;

  int checks;
  int failures;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .ms_ex_int         (ms_ex_int),
    .ws_block          (ws_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream bus builder (bit positions counted from the LSB).
  function automatic logic [163:0] mk(input logic [4:0] ld, input logic rfm, input logic mw,
                                      input logic gw, input logic [4:0] dst,
                                      input logic [31:0] res, input logic [31:0] pc,
                                      input logic mexc);
    logic [163:0] b;
    b          = '0;
    b[31:0]    = pc;
    b[63:32]   = res;
    b[68:64]   = dst;
    b[69]      = gw;
    b[70]      = mw;
    b[71]      = rfm;
    b[76:72]   = ld;
    b[160]     = mexc;
    return b;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ms_to_ws_valid); end
    checks++;
    if (ms_allowin !== 1'b1) begin failures++; $display("FAIL reset_allowin got=%b exp=1", ms_allowin); end
    checks++;
    if (ms_ex_int !== 1'b0) begin failures++; $display("FAIL reset_ex_int got=%b exp=0", ms_ex_int); end
    checks++;
    if ({ms_to_ds_bus[54], ms_to_ds_bus[53], ms_to_ds_bus[38], ms_to_ds_bus[0]} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_fwd_bits got=%b exp=0000",
               {ms_to_ds_bus[54], ms_to_ds_bus[53], ms_to_ds_bus[38], ms_to_ds_bus[0]});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_ld_byte();
    logic [4:0]  sel [2];
    logic [31:0] exp [2];
    sel[0] = 5'b00010; exp[0] = 32'hFFFF_FF80;
    sel[1] = 5'b01000; exp[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      ws_allowin     = 1'b1;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk(sel[i], 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_1003, 32'h1c00_0000, 1'b0);
      step();
      es_to_ms_valid = 1'b0;
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL ldb_wait_valid[%0d] got=%b exp=0", i, ms_to_ws_valid); end
      checks++;
      if (ms_to_ds_bus[0] !== 1'b1) begin failures++; $display("FAIL ldb_pending[%0d] got=%b exp=1", i, ms_to_ds_bus[0]); end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h80FF_1234;
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL ldb_ok_valid[%0d] got=%b exp=1", i, ms_to_ws_valid); end
      checks++;
      if (ms_to_ws_bus[63:32] !== exp[i]) begin failures++; $display("FAIL ldb_final[%0d] got=%h exp=%h", i, ms_to_ws_bus[63:32], exp[i]); end
      checks++;
      if (ms_to_ds_bus[32:1] !== exp[i]) begin failures++; $display("FAIL ldb_fwd[%0d] got=%h exp=%h", i, ms_to_ds_bus[32:1], exp[i]); end
      step();
      data_sram_data_ok = 1'b0;
      #1;
      checks++;
      if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL ldb_gone[%0d] got=%b exp=0", i, ms_to_ws_valid); end
    end
  endtask

  task automatic test_ld_hu_stall();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(5'b10000, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_2002, 32'h1c00_0010, 1'b0);
    step();
    es_to_ms_valid    = 1'b0;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_0000;
    #1;
    checks++;
    if (ms_allowin !== 1'b0) begin failures++; $display("FAIL hu_ok_allowin got=%b exp=0", ms_allowin); end
    checks++;
    if (ms_to_ds_bus[0] !== 1'b0) begin failures++; $display("FAIL hu_ok_pending got=%b exp=0", ms_to_ds_bus[0]); end
    step();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hAAAA_5555;
    #1;
    checks++;
    if (ms_to_ws_bus[63:32] !== 32'h0000_BEEF) begin failures++; $display("FAIL hu_buf_final got=%h exp=0000beef", ms_to_ws_bus[63:32]); end
    checks++;
    if (ms_allowin !== 1'b0) begin failures++; $display("FAIL hu_buf_allowin got=%b exp=0", ms_allowin); end
    checks++;
    if (ms_to_ds_bus[0] !== 1'b0) begin failures++; $display("FAIL hu_buf_pending got=%b exp=0", ms_to_ds_bus[0]); end
    step();
    checks++;
    if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL hu_hold_valid got=%b exp=1", ms_to_ws_valid); end
    step();
    ws_allowin = 1'b1;
    #1;
    checks++;
    if (ms_allowin !== 1'b1) begin failures++; $display("FAIL hu_rel_allowin got=%b exp=1", ms_allowin); end
    checks++;
    if (ms_to_ws_bus[63:32] !== 32'h0000_BEEF) begin failures++; $display("FAIL hu_rel_final got=%h exp=0000beef", ms_to_ws_bus[63:32]); end
    step();
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL hu_gone got=%b exp=0", ms_to_ws_valid); end
  endtask

  task automatic test_alu();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(5'b00000, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h1c00_0020, 1'b0);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL alu_valid got=%b exp=1", ms_to_ws_valid); end
    checks++;
    if (ms_to_ds_bus[38:33] !== 6'b1_00101) begin failures++; $display("FAIL alu_we_dest got=%b exp=100101", ms_to_ds_bus[38:33]); end
    checks++;
    if (ms_to_ds_bus[32:1] !== 32'h0000_1234) begin failures++; $display("FAIL alu_fwd got=%h exp=00001234", ms_to_ds_bus[32:1]); end
    checks++;
    if (ms_to_ws_bus[63:32] !== 32'h0000_1234) begin failures++; $display("FAIL alu_final got=%h exp=00001234", ms_to_ws_bus[63:32]); end
    step();
    checks++;
    if ({ms_to_ws_valid, ms_to_ds_bus[38]} !== 2'b00) begin failures++; $display("FAIL alu_gone got=%b exp=00", {ms_to_ws_valid, ms_to_ds_bus[38]}); end
  endtask

  task automatic test_flush_discard();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(5'b00001, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_3000, 32'h1c00_0030, 1'b0);
    step();
    es_to_ms_valid = 1'b0;
    ws_block       = 1'b1;
    step();
    ws_block       = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(5'b00001, 1'b1, 1'b0, 1'b1, 5'd9, 32'h0000_3004, 32'h1c00_0034, 1'b0);
    #1;
    checks++;
    if ({ms_allowin, ms_to_ws_valid} !== 2'b10) begin failures++; $display("FAIL flush_empty got=%b exp=10", {ms_allowin, ms_to_ws_valid}); end
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_DEAD;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL stale_dropped got=%b exp=0", ms_to_ws_valid); end
    checks++;
    if (ms_to_ds_bus[0] !== 1'b1) begin failures++; $display("FAIL stale_pending got=%b exp=1", ms_to_ds_bus[0]); end
    step();
    data_sram_data_ok = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b0) begin failures++; $display("FAIL stale_wait got=%b exp=0", ms_to_ws_valid); end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0011;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_to_ws_bus[63:32]} !== {1'b1, 32'h0000_0011}) begin
      failures++;
      $display("FAIL second_load got=%b/%h exp=1/00000011", ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_flush_with_data_ok();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(5'b00001, 1'b1, 1'b0, 1'b1, 5'd10, 32'h0000_3100, 32'h1c00_0040, 1'b0);
    step();
    es_to_ms_valid    = 1'b0;
    ws_block          = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0BAD;
    step();
    ws_block          = 1'b0;
    data_sram_data_ok = 1'b0;
    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = mk(5'b00001, 1'b1, 1'b0, 1'b1, 5'd11, 32'h0000_3104, 32'h1c00_0044, 1'b0);
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0022;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_to_ws_bus[63:32]} !== {1'b1, 32'h0000_0022}) begin
      failures++;
      $display("FAIL flush_ok_no_discard got=%b/%h exp=1/00000022", ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic test_mem_exce();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(5'b00001, 1'b1, 1'b0, 1'b1, 5'd4, 32'h0000_4001, 32'h1c00_0050, 1'b1);
    step();
    es_to_ms_valid = 1'b0;
    #1;
    checks++;
    if (ms_to_ws_valid !== 1'b1) begin failures++; $display("FAIL exce_valid got=%b exp=1", ms_to_ws_valid); end
    checks++;
    if (ms_ex_int !== 1'b1) begin failures++; $display("FAIL exce_ex_int got=%b exp=1", ms_ex_int); end
    checks++;
    if (ms_to_ws_bus[153] !== 1'b1) begin failures++; $display("FAIL exce_bus_bit got=%b exp=1", ms_to_ws_bus[153]); end
    step();
    checks++;
    if ({ms_to_ws_valid, ms_ex_int} !== 2'b00) begin failures++; $display("FAIL exce_gone got=%b exp=00", {ms_to_ws_valid, ms_ex_int}); end
  endtask

  task automatic test_reset_discard();
    ws_allowin     = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(5'b00001, 1'b1, 1'b0, 1'b1, 5'd12, 32'h0000_5000, 32'h1c00_0060, 1'b0);
    step();
    es_to_ms_valid = 1'b0;
    ws_block       = 1'b1;
    step();
    ws_block = 1'b0;
    reset    = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if ({ms_allowin, ms_to_ws_valid} !== 2'b10) begin failures++; $display("FAIL rst_disc_state got=%b exp=10", {ms_allowin, ms_to_ws_valid}); end
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(5'b00001, 1'b1, 1'b0, 1'b1, 5'd13, 32'h0000_5004, 32'h1c00_0064, 1'b0);
    step();
    es_to_ms_valid    = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0055;
    #1;
    checks++;
    if ({ms_to_ws_valid, ms_to_ws_bus[63:32]} !== {1'b1, 32'h0000_0055}) begin
      failures++;
      $display("FAIL rst_disc_cleared got=%b/%h exp=1/00000055", ms_to_ws_valid, ms_to_ws_bus[63:32]);
    end
    step();
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    reset             = 1'b1;
    ws_allowin        = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_block          = 1'b0;
    test_reset();
    test_ld_byte();
    test_ld_hu_stall();
    test_alu();
    test_flush_discard();
    test_flush_with_data_ok();
    test_mem_exce();
    test_reset_discard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
